// File: rtl/cond_logic_if.sv
// Bus bundle for cond_logic: decoder requests and flags in, qualified write enables out.
// skip_cnt is always present on the bus; it reads 0 unless COND_LOGIC_SKIP_CNT_EN is defined.
interface cond_logic_if;
    logic        en;
    logic [3:0]  cond;
    logic [3:0]  alu_flags;
    logic [1:0]  flag_w;
    logic        pc_s;
    logic        reg_w;
    logic        mem_w;
    logic        no_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_write;
    logic        cond_ex;
    logic [3:0]  flags;
    logic [31:0] skip_cnt;

    modport master (
        output en, cond, alu_flags, flag_w, pc_s, reg_w, mem_w, no_write,
        input  pc_src, reg_write, mem_write, cond_ex, flags, skip_cnt
    );

    modport slave (
        input  en, cond, alu_flags, flag_w, pc_s, reg_w, mem_w, no_write,
        output pc_src, reg_write, mem_write, cond_ex, flags, skip_cnt
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition field against the flag register,
// gates the write enables and updates {N,Z,C,V}. Optional squash counter: COND_LOGIC_SKIP_CNT_EN.
module cond_logic (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);
    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;
    logic       w_condEx;
    logic       w_pass;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition uses only the registered flags, so a flag write is seen one cycle later.
    always_comb begin
        w_condEx = 1'b0;
        case (bus.cond)
            4'b0000: w_condEx = w_z;
            4'b0001: w_condEx = !w_z;
            4'b0010: w_condEx = w_c;
            4'b0011: w_condEx = !w_c;
            4'b0100: w_condEx = w_n;
            4'b0101: w_condEx = !w_n;
            4'b0110: w_condEx = w_v;
            4'b0111: w_condEx = !w_v;
            4'b1000: w_condEx = w_c && !w_z;
            4'b1001: w_condEx = !w_c || w_z;
            4'b1010: w_condEx = (w_n == w_v);
            4'b1011: w_condEx = (w_n != w_v);
            4'b1100: w_condEx = !w_z && (w_n == w_v);
            4'b1101: w_condEx = w_z || (w_n != w_v);
            4'b1110: w_condEx = 1'b1;
            default: w_condEx = 1'b0;
        endcase
    end

    assign w_pass        = bus.en && w_condEx;
    assign bus.cond_ex   = w_condEx;
    assign bus.pc_src    = w_pass && bus.pc_s;
    assign bus.reg_write = w_pass && bus.reg_w && !bus.no_write;
    assign bus.mem_write = w_pass && bus.mem_w;
    assign bus.flags     = r_flags;

    // N,Z and C,V are written as independent groups.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_pass && bus.flag_w[1]) r_flags[3:2] <= bus.alu_flags[3:2];
            if (w_pass && bus.flag_w[0]) r_flags[1:0] <= bus.alu_flags[1:0];
        end
    end

`ifdef COND_LOGIC_SKIP_CNT_EN
    logic [31:0] r_skipCnt;

    // Counts valid instructions whose condition failed; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skipCnt <= 32'd0;
        end else if (bus.en && !w_condEx && (r_skipCnt != 32'hFFFF_FFFF)) begin
            r_skipCnt <= r_skipCnt + 32'd1;
        end
    end

    assign bus.skip_cnt = r_skipCnt;
`else
    assign bus.skip_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vector table, randomized run against a
// behavioural model, and hand-written reset / skip-counter sequences.
module tb_cond_logic;
    logic clk = 1'b0;
    logic reset = 1'b1;
    cond_logic_if bus ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcS, regW, memW, noWr;
        logic       eCond, ePc, eReg, eMem;
        logic [3:0] eFlags;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [3:0]  mFlags = 4'b0000;
    logic [31:0] mSkip = 32'd0;
    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic [3:0] cond, logic [3:0] alu, logic [1:0] fw,
                                logic pcS, logic regW, logic memW, logic noWr,
                                logic eCond, logic ePc, logic eReg, logic eMem, logic [3:0] eFlags);
        vec_t v;
        v.en = en; v.cond = cond; v.alu = alu; v.fw = fw;
        v.pcS = pcS; v.regW = regW; v.memW = memW; v.noWr = noWr;
        v.eCond = eCond; v.ePc = ePc; v.eReg = eReg; v.eMem = eMem; v.eFlags = eFlags;
        return v;
    endfunction

    // Conditions come in complementary pairs; odd codes invert the even one.
    function automatic logic modelCond(logic [3:0] c, logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [31:0] expSkip();
`ifdef COND_LOGIC_SKIP_CNT_EN
        return mSkip;
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveIn(input vec_t v);
        bus.en = v.en; bus.cond = v.cond; bus.alu_flags = v.alu; bus.flag_w = v.fw;
        bus.pc_s = v.pcS; bus.reg_w = v.regW; bus.mem_w = v.memW; bus.no_write = v.noWr;
    endtask

    // Model the state change at a rising edge from the inputs present at that edge.
    task automatic modelEdge();
        logic ok;
        if (reset) begin
            mFlags = 4'b0000;
            mSkip = 32'd0;
        end else begin
            ok = modelCond(bus.cond, mFlags);
            if (bus.en && ok && bus.flag_w[1]) mFlags[3:2] = bus.alu_flags[3:2];
            if (bus.en && ok && bus.flag_w[0]) mFlags[1:0] = bus.alu_flags[1:0];
            if (bus.en && !ok && mSkip != 32'hFFFF_FFFF) mSkip = mSkip + 32'd1;
        end
    endtask

    task automatic checkComb(input string tag);
        logic c;
        c = modelCond(bus.cond, mFlags);
        checkOutput({tag, " cond_ex"}, 32'(bus.cond_ex), 32'(c));
        checkOutput({tag, " pc_src"}, 32'(bus.pc_src), 32'(bus.en & c & bus.pc_s));
        checkOutput({tag, " reg_write"}, 32'(bus.reg_write), 32'(bus.en & c & bus.reg_w & ~bus.no_write));
        checkOutput({tag, " mem_write"}, 32'(bus.mem_write), 32'(bus.en & c & bus.mem_w));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        driveIn(v);
        #1;
        checkComb(tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput({tag, " flags"}, 32'(bus.flags), 32'(mFlags));
        checkOutput({tag, " skip_cnt"}, bus.skip_cnt, expSkip());
    endtask

    initial begin
        vec_t v;
        v = mk(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        driveIn(v);
        #1;
        checkOutput("reset flags", 32'(bus.flags), 32'h0);
        checkOutput("reset skip_cnt", bus.skip_cnt, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        //          en cond  alu   fw    pc rw mw nw  eC eP eR eM eFlags
        vecs.push_back(mk(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(1, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 4'h4));
        vecs.push_back(mk(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 1, 0, 1, 0, 4'h4));
        vecs.push_back(mk(1, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'h4));
        vecs.push_back(mk(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 4'hF));
        vecs.push_back(mk(1, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 4'h3));
        vecs.push_back(mk(1, 4'hE, 4'h8, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(1, 4'hE, 4'h8, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 4'h8));
        vecs.push_back(mk(1, 4'hA, 4'h6, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 4'h8));
        vecs.push_back(mk(1, 4'hB, 4'h1, 2'b01, 0, 1, 0, 0, 1, 0, 1, 0, 4'h9));
        vecs.push_back(mk(0, 4'hE, 4'h0, 2'b11, 1, 1, 1, 0, 1, 0, 0, 0, 4'h9));
        vecs.push_back(mk(1, 4'hE, 4'h0, 2'b00, 1, 1, 1, 1, 1, 1, 0, 1, 4'h9));
        vecs.push_back(mk(1, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 0, 4'h9));

        foreach (vecs[i]) begin
            @(negedge clk);
            driveIn(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d cond_ex", i), 32'(bus.cond_ex), 32'(vecs[i].eCond));
            checkOutput($sformatf("vec%0d pc_src", i), 32'(bus.pc_src), 32'(vecs[i].ePc));
            checkOutput($sformatf("vec%0d reg_write", i), 32'(bus.reg_write), 32'(vecs[i].eReg));
            checkOutput($sformatf("vec%0d mem_write", i), 32'(bus.mem_write), 32'(vecs[i].eMem));
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput($sformatf("vec%0d flags", i), 32'(bus.flags), 32'(vecs[i].eFlags));
        end
        checkOutput("table skip_cnt", bus.skip_cnt, expSkip());

        for (int i = 0; i < 300; i++) begin
            v.en = ($urandom_range(0, 7) != 0);
            v.cond = 4'($urandom);
            v.alu = 4'($urandom);
            v.fw = 2'($urandom);
            v.pcS = 1'($urandom); v.regW = 1'($urandom);
            v.memW = 1'($urandom); v.noWr = 1'($urandom);
            applyStimulus(v, "rand");
        end

        // Async reset clears flags between edges, outputs follow cleared flags.
        applyStimulus(mk(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "preset");
        @(negedge clk);
        reset = 1'b1;
        driveIn(mk(1, 4'h1, 4'hF, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0));
        #1;
        mFlags = 4'h0;
        mSkip = 32'd0;
        checkOutput("async flags", 32'(bus.flags), 32'h0);
        checkOutput("async skip_cnt", bus.skip_cnt, 32'h0);
        checkOutput("in-reset cond_ex NE", 32'(bus.cond_ex), 32'h1);
        checkOutput("in-reset pc_src", 32'(bus.pc_src), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("reset-edge discard", 32'(bus.flags), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(mk(1, 4'hE, 4'hA, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "first edge");
        checkOutput("first edge flags", 32'(bus.flags), 32'hA);

`ifdef COND_LOGIC_SKIP_CNT_EN
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        mFlags = 4'h0;
        mSkip = 32'd0;
        for (int i = 0; i < 3; i++) applyStimulus(mk(1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "skip");
        for (int i = 0; i < 2; i++) applyStimulus(mk(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "noskip");
        checkOutput("skip count 3", bus.skip_cnt, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("skip reset", bus.skip_cnt, 32'd0);
        reset = 1'b0;
        mFlags = 4'h0;
        mSkip = 32'hFFFF_FFFD;
        force dut.r_skipCnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_skipCnt;
        for (int i = 0; i < 4; i++) applyStimulus(mk(1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "sat");
        checkOutput("skip saturate", bus.skip_cnt, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  instruction-valid strobe; 0 = bubble or stall, so no state update and all write enables forced 0.
REQ-005 cond  input  4  instruction condition field, bits [31:28].
REQ-006 alu_flags  input  4  ALU result flags {N,Z,C,V} for the current instruction.
REQ-007 flag_w  input  2  flag-write request from the ALU decoder: [1] writes N,Z; [0] writes C,V.
REQ-008 pc_s, reg_w, mem_w  input  1 each  unconditional PC, register and memory write requests from the main decoder.
REQ-009 no_write  input  1  compare/test instruction, so the register write is suppressed.
REQ-010 pc_src, reg_write, mem_write  output  1 each  condition-qualified write enables.
REQ-011 cond_ex  output  1  condition passed for the current instruction.
REQ-012 flags  output  4  architectural flag register {N,Z,C,V}.
REQ-013 skip_cnt  output  32  count of squashed instructions; present only under the configuration macro.

Function
REQ-014 cond_ex SHALL be combinational from cond and the registered flags, never from alu_flags, per this table:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C&!Z
- 1001 LS: !C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 0
REQ-015 pc_src SHALL equal en & cond_ex & pc_s.
REQ-016 reg_write SHALL equal en & cond_ex & reg_w & !no_write.
REQ-017 mem_write SHALL equal en & cond_ex & mem_w.
REQ-018 At a rising clk edge with en & cond_ex & flag_w[1], flags[3:2] SHALL load alu_flags[3:2].
REQ-019 At a rising clk edge with en & cond_ex & flag_w[0], flags[1:0] SHALL load alu_flags[1:0].
REQ-020 Otherwise flags SHALL hold; flag groups update independently.
REQ-021 Updated flags SHALL become visible to cond_ex in the cycle after the writing instruction, with one-cycle latency and no bypass.
REQ-022 A failed condition SHALL suppress flag writes, even with S=1.
REQ-023 When en=0, all outputs except flags, cond_ex and skip_cnt SHALL be 0, and no state SHALL change.

Reset
REQ-024 When reset is asserted, flags SHALL be cleared to 0000 immediately, without waiting for clk.
REQ-025 When reset is asserted, skip_cnt SHALL be cleared to 0 immediately, without waiting for clk.
REQ-026 During reset, outputs SHALL follow REQ-014 to REQ-017 using the cleared flags.
REQ-027 Reset asserted mid-operation SHALL discard any same-edge flag update.
REQ-028 The first edge after reset deassertion SHALL update state normally.

Configuration
REQ-029 Macro COND_LOGIC_SKIP_CNT_EN SHALL control the skip counter.
REQ-030 With COND_LOGIC_SKIP_CNT_EN defined, skip_cnt SHALL increment by 1 at each rising edge where en=1 and cond_ex=0.
REQ-031 With COND_LOGIC_SKIP_CNT_EN defined, skip_cnt SHALL saturate at 32'hFFFF_FFFF and not wrap.
REQ-032 With COND_LOGIC_SKIP_CNT_EN undefined, skip_cnt SHALL be the constant 0 and no counter register SHALL be inferred.

Verification
REQ-033 Reset, then cond=0000 (EQ), en=1 -> cond_ex=0, reg_write=0, flags=0000.
REQ-034 cond=1110, flag_w=11, alu_flags=0100 (Z) on one edge; next cycle cond=0000 -> flags=0100 and cond_ex=1; cond=0001 -> cond_ex=0.
REQ-035 flags=1111; cond=1110, flag_w=10, alu_flags=0000 -> flags=0011 after the edge (C,V held).
REQ-036 flags=1000 (N); cond=1010 (GE), reg_w=1, flag_w=11 -> cond_ex=0, reg_write=0, flags unchanged.
REQ-037 cond=1110, reg_w=1, no_write=1, mem_w=1, pc_s=1 -> reg_write=0, mem_write=1, pc_src=1.
REQ-038 With COND_LOGIC_SKIP_CNT_EN: 3 failing instructions with en=1 plus 2 with en=0 -> skip_cnt=3; reset -> 0; preload near max -> holds at FFFF_FFFF.
